// File: rtl/xadc_sample_reader_pkg.sv
// Shared station package for the XADC temperature path.
// Holds the reader FSM state encoding, the XADC VAUX DRP addresses, the
// temperature thresholds shared with the material FSM, and a helper that
// extracts the 12-bit conversion result from a DRP read word.
package xadc_sample_reader_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  // Reader FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_ACC     = 3'd3;
  localparam logic [2:0] ST_PUBLISH = 3'd4;

  // XADC auxiliary-channel status register addresses
  localparam logic [DRP_ADDR_W-1:0] VAUX0_ADDR = 7'h10;
  localparam logic [DRP_ADDR_W-1:0] VAUX1_ADDR = 7'h11;
  localparam logic [DRP_ADDR_W-1:0] VAUX6_ADDR = 7'h16;  // thermistor input
  localparam logic [DRP_ADDR_W-1:0] VAUX7_ADDR = 7'h17;

  // Temperature thresholds shared with the station material FSM
  localparam logic [SAMPLE_W-1:0] THRESHOLD1 = 12'd1200;
  localparam logic [SAMPLE_W-1:0] THRESHOLD2 = 12'd1900;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // The XADC left-justifies its 12-bit result in the 16-bit DRP word.
  function automatic sample_t drp_sample(input logic [DRP_DATA_W-1:0] drp_word);
    return drp_word[DRP_DATA_W-1:DRP_DATA_W-SAMPLE_W];
  endfunction

endpackage

// File: rtl/xadc_sample_reader_if.sv
// Bus between the XADC primitive / station system and the sample reader.
// Signals:
//   eoc         end-of-conversion pulse from the XADC
//   den, dwe    DRP enable pulse / write enable (always 0)
//   daddr       DRP address
//   drdy        DRP read-data valid pulse
//   drp_do      DRP read data (XADC "do" port; sample in bits [15:4])
//   digitalTemp averaged temperature sample
//   ready       one-cycle pulse when digitalTemp updates
//   drpTimeout  one-cycle pulse when a DRP read is abandoned
// master = the reader, slave = XADC + consumer side.
interface xadc_sample_reader_if;
  import xadc_sample_reader_pkg::*;

  logic                  eoc;
  logic                  den;
  logic                  dwe;
  logic [DRP_ADDR_W-1:0] daddr;
  logic                  drdy;
  logic [DRP_DATA_W-1:0] drp_do;
  logic [SAMPLE_W-1:0]   digitalTemp;
  logic                  ready;
  logic                  drpTimeout;

  modport master (
    input  eoc, drdy, drp_do,
    output den, dwe, daddr, digitalTemp, ready, drpTimeout
  );

  modport slave (
    output eoc, drdy, drp_do,
    input  den, dwe, daddr, digitalTemp, ready, drpTimeout
  );

endinterface

// File: rtl/xadc_sample_reader_sample_averager.sv
// sample_averager: sums 2^AVG_LOG2 consecutive samples and divides by shift.
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   add       add `sample` into the running window this cycle
//   sample    12-bit sample to add
//   done      high in the add cycle that completes the window
//   avg       window average including this cycle's sample (valid with done)
// The window restarts automatically on the completing add.
module sample_averager
  import xadc_sample_reader_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                add,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                done,
  output logic [SAMPLE_W-1:0] avg
);

  // 2^AVG_LOG2 samples of at most 12'hFFF cannot exceed this width
  localparam int AW = SAMPLE_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_q, acc_d, sum_s;
  logic [CW-1:0] cnt_q, cnt_d;

  // Running sum, completion detect and next accumulator/count
  always_comb begin
    sum_s = acc_q + AW'(sample);
    done  = add && (cnt_q == CNT_LAST);
    avg   = SAMPLE_W'(sum_s >> AVG_LOG2);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (add) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = {AW{1'b0}};
        cnt_d = {CW{1'b0}};
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Accumulator and sample-count registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xadc_sample_reader.sv
// xadc_sample_reader: on each XADC end-of-conversion, reads the configured
// VAUX channel over DRP, averages 2^AVG_LOG2 samples and publishes the
// average on digitalTemp with a one-cycle ready pulse.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset
//   bus  xadc_sample_reader_if.master (eoc, DRP handshake, results)
// An eoc arriving while a read is in flight is remembered (one deep) and
// starts the next read as soon as the FSM returns to IDLE.
module xadc_sample_reader
  import xadc_sample_reader_pkg::*;
#(
  parameter logic [DRP_ADDR_W-1:0] CHANNEL_ADDR = VAUX6_ADDR,
  parameter int                    AVG_LOG2     = 2,
  parameter int                    DRP_TIMEOUT  = 63
) (
  input  logic                 CLK,
  input  logic                 RST,
  xadc_sample_reader_if.master bus
);

  localparam int TW = $clog2(DRP_TIMEOUT + 2);
  localparam logic [TW-1:0] TO_LIM = TW'(DRP_TIMEOUT);

  logic [2:0]          state_q, state_d;
  logic                pending_q, pending_d;
  logic [TW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                den_q, den_d;
  logic                timeout_q, timeout_d;
  logic                ready_q, ready_d;
  logic [SAMPLE_W-1:0] temp_q, temp_d;

  logic                add_s;
  logic                done_s;
  logic [SAMPLE_W-1:0] avg_s;

  sample_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .CLK    (CLK),
    .RST    (RST),
    .add    (add_s),
    .sample (sample_q),
    .done   (done_s),
    .avg    (avg_s)
  );

  // Read FSM, DRP wait counter and pending-request flag
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    wait_cnt_d = wait_cnt_q;
    sample_d   = sample_q;
    temp_d     = temp_q;
    add_s      = 1'b0;
    timeout_d  = 1'b0;
    ready_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.eoc || pending_q) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        pending_d  = 1'b0;
        // counts cycles since den, so the limit compare matches DRP_TIMEOUT
        wait_cnt_d = TW'(1);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // drdy has priority over a timeout in the same cycle
        if (bus.drdy) begin
          sample_d = drp_sample(bus.drp_do);
          state_d  = ST_ACC;
        end else if (wait_cnt_q == TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      ST_ACC: begin
        add_s = 1'b1;
        // the averager clears itself on the completing add, so the
        // average is registered here and appears during PUBLISH
        if (done_s) begin
          temp_d  = avg_s;
          ready_d = 1'b1;
          state_d = ST_PUBLISH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUBLISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // a new eoc outside IDLE wins over the clear in REQ
    if (bus.eoc && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    den_d = (state_d == ST_REQ);
  end

  // State and registered-output flops
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      wait_cnt_q <= {TW{1'b0}};
      sample_q   <= {SAMPLE_W{1'b0}};
      den_q      <= 1'b0;
      timeout_q  <= 1'b0;
      ready_q    <= 1'b0;
      temp_q     <= {SAMPLE_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wait_cnt_q <= wait_cnt_d;
      sample_q   <= sample_d;
      den_q      <= den_d;
      timeout_q  <= timeout_d;
      ready_q    <= ready_d;
      temp_q     <= temp_d;
    end
  end

  assign bus.den         = den_q;
  assign bus.dwe         = 1'b0;
  assign bus.daddr       = CHANNEL_ADDR;
  assign bus.digitalTemp = temp_q;
  assign bus.ready       = ready_q;
  assign bus.drpTimeout  = timeout_q;

endmodule

// File: tb/tb_xadc_sample_reader.sv
// Testbench for xadc_sample_reader: one instance without averaging
// (AVG_LOG2=0) and one averaging four samples (AVG_LOG2=2), each on its own
// bus. Expected results come from a window-of-samples model kept here.
module tb_xadc_sample_reader;
  import xadc_sample_reader_pkg::*;

  localparam int TO = 63;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   den_cnt2 = 0;

  // reference model: samples in the current window and last published value
  int unsigned q0[$];
  int unsigned q2[$];
  logic [11:0] held0;
  logic [11:0] held2;

  xadc_sample_reader_if bus0 ();
  xadc_sample_reader_if bus2 ();

  xadc_sample_reader #(.CHANNEL_ADDR(7'h16), .AVG_LOG2(0), .DRP_TIMEOUT(TO)) dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (bus0)
  );

  xadc_sample_reader #(.CHANNEL_ADDR(7'h16), .AVG_LOG2(2), .DRP_TIMEOUT(TO)) dut2 (
    .CLK (clk),
    .RST (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus2.den === 1'b1) den_cnt2 <= den_cnt2 + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] get_den(input int sel);
    return (sel == 0) ? {15'd0, bus0.den} : {15'd0, bus2.den};
  endfunction
  function automatic logic [15:0] get_rdy(input int sel);
    return (sel == 0) ? {15'd0, bus0.ready} : {15'd0, bus2.ready};
  endfunction
  function automatic logic [15:0] get_to(input int sel);
    return (sel == 0) ? {15'd0, bus0.drpTimeout} : {15'd0, bus2.drpTimeout};
  endfunction
  function automatic logic [15:0] get_temp(input int sel);
    return (sel == 0) ? {4'd0, bus0.digitalTemp} : {4'd0, bus2.digitalTemp};
  endfunction

  task automatic drv(input int sel, input logic e, input logic r, input logic [15:0] d);
    if (sel == 0) begin
      bus0.eoc = e; bus0.drdy = r; bus0.drp_do = d;
    end else begin
      bus2.eoc = e; bus2.drdy = r; bus2.drp_do = d;
    end
  endtask

  // model: add a sample; publish the truncated mean when the window is full
  task automatic model_push(input int sel, input logic [15:0] word, output bit pub);
    int unsigned sum;
    int unsigned s;
    s   = word / 16;
    pub = 1'b0;
    sum = 0;
    if (sel == 0) begin
      q0.push_back(s);
      if (q0.size() == 1) begin
        foreach (q0[i]) sum += q0[i];
        held0 = 12'(sum / 1);
        q0.delete();
        pub = 1'b1;
      end
    end else begin
      q2.push_back(s);
      if (q2.size() == 4) begin
        foreach (q2[i]) sum += q2[i];
        held2 = 12'(sum / 4);
        q2.delete();
        pub = 1'b1;
      end
    end
  endtask

  function automatic logic [11:0] held(input int sel);
    return (sel == 0) ? held0 : held2;
  endfunction

  // pulse eoc in an idle cycle; den must follow in the next cycle
  task automatic start_read(input int sel);
    drv(sel, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    drv(sel, 1'b0, 1'b0, 16'h0000);
    chk("den_after_eoc", get_den(sel), 16'd1);
  endtask

  // answer the outstanding read with drdy `lat` cycles after den
  task automatic respond(input int sel, input logic [15:0] data, input int lat);
    bit pub;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("den_single_pulse", get_den(sel), 16'd0);
      chk("no_timeout_while_waiting", get_to(sel), 16'd0);
    end
    drv(sel, 1'b0, 1'b1, data);
    @(negedge clk);
    drv(sel, 1'b0, 1'b0, 16'h0000);
    chk("ready_not_at_acc", get_rdy(sel), 16'd0);
    chk("drdy_beats_timeout", get_to(sel), 16'd0);
    model_push(sel, data, pub);
    @(negedge clk);
    chk("ready_pulse", get_rdy(sel), {15'd0, pub});
    chk("digital_temp", get_temp(sel), {4'd0, held(sel)});
    @(negedge clk);
    chk("ready_one_cycle", get_rdy(sel), 16'd0);
  endtask

  // read that never gets drdy
  task automatic timeout_read(input int sel);
    start_read(sel);
    for (int i = 1; i <= TO + 1; i++) begin
      @(negedge clk);
      chk("drp_timeout_timing", get_to(sel), {15'd0, (i == TO + 1)});
      chk("no_ready_on_timeout", get_rdy(sel), 16'd0);
    end
    @(negedge clk);
    chk("drp_timeout_one_cycle", get_to(sel), 16'd0);
  endtask

  task automatic check_reset_outputs(input int sel);
    chk("rst_den", get_den(sel), 16'd0);
    chk("rst_ready", get_rdy(sel), 16'd0);
    chk("rst_timeout", get_to(sel), 16'd0);
    chk("rst_temp", get_temp(sel), 16'd0);
    chk("rst_dwe", (sel == 0) ? {15'd0, bus0.dwe} : {15'd0, bus2.dwe}, 16'd0);
    chk("rst_daddr", (sel == 0) ? {9'd0, bus0.daddr} : {9'd0, bus2.daddr}, 16'h0016);
  endtask

  initial begin
    logic [11:0] smp_tab [4];
    logic [15:0] dv;
    int          snap;
    bit          pub;
    int          dk;

    smp_tab[0] = 12'd1196; smp_tab[1] = 12'd1200;
    smp_tab[2] = 12'd1204; smp_tab[3] = 12'd1201;
    held0 = 12'd0;
    held2 = 12'd0;
    rst   = 1'b1;
    drv(0, 1'b0, 1'b0, 16'h0000);
    drv(2, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(2);

    // no averaging: 16'h7D00 with drdy five cycles after den
    start_read(0);
    respond(0, 16'h7D00, 5);
    chk("avg0_7d0", get_temp(0), 16'h07D0);

    // no averaging: random data and latency
    for (int r = 0; r < 6; r++) begin
      start_read(0);
      respond(0, 16'($urandom), $urandom_range(1, 12));
    end

    // drdy in the very cycle the timeout would fire
    start_read(0);
    respond(0, 16'h5A3C, TO);
    timeout_read(0);

    // four-sample average around threshold 1
    for (int r = 0; r < 4; r++) begin
      dv = {smp_tab[r], 4'($urandom)};
      start_read(2);
      respond(2, dv, $urandom_range(1, 10));
    end
    chk("avg2_1200", get_temp(2), 16'd1200);

    // timed-out read is not counted in the next window
    timeout_read(2);

    // two eoc during WAIT give exactly one extra read
    snap = den_cnt2;
    start_read(2);
    @(negedge clk); drv(2, 1'b1, 1'b0, 16'h0000);
    @(negedge clk); drv(2, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); drv(2, 1'b1, 1'b0, 16'h0000);
    dv = 16'($urandom);
    @(negedge clk); drv(2, 1'b0, 1'b1, dv);
    @(negedge clk); drv(2, 1'b0, 1'b0, 16'h0000);
    chk("pend_ready_not_at_acc", get_rdy(2), 16'd0);
    model_push(2, dv, pub);
    dk = pub ? 4 : 3;
    for (int k = 2; k <= dk; k++) begin
      @(negedge clk);
      chk("pend_den_timing", get_den(2), {15'd0, (k == dk)});
      if (k == 2) begin
        chk("pend_ready", get_rdy(2), {15'd0, pub});
        chk("pend_temp", get_temp(2), {4'd0, held2});
      end
    end
    respond(2, 16'($urandom), $urandom_range(1, 8));
    repeat (6) @(negedge clk);
    chk("pend_den_count", 16'(den_cnt2 - snap), 16'd2);

    // complete the window with random reads
    for (int r = 0; r < 2; r++) begin
      start_read(2);
      respond(2, 16'($urandom), $urandom_range(1, 10));
    end

    // full-scale samples must not overflow
    for (int r = 0; r < 4; r++) begin
      start_read(2);
      respond(2, {12'hFFF, 4'($urandom)}, $urandom_range(1, 6));
    end
    chk("avg2_fff", get_temp(2), 16'h0FFF);

    // reset during WAIT, then a late drdy
    start_read(2);
    respond(2, 16'($urandom), 3);
    start_read(2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drv(2, 1'b0, 1'b1, 16'hABC0);
    q0.delete(); q2.delete();
    held0 = 12'd0; held2 = 12'd0;
    @(negedge clk);
    drv(2, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      check_reset_outputs(2);
      chk("rst_acc_cleared", {2'b00, dut2.u_avg.acc_q}, 16'd0);
      @(negedge clk);
    end
    check_reset_outputs(0);

    // a window after reset averages only post-reset samples
    for (int r = 0; r < 4; r++) begin
      start_read(2);
      respond(2, 16'($urandom), $urandom_range(1, 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
